riscv_tag_check_unit: RTL and testbench

- Parametrised, registered successor to the single-bit tag check logic in the RI5CY DIFT pipeline. It sits in EX alongside the ALU.
- Checks multi-bit tags of source A, source B and destination against a per-instruction-class policy table.
- Captures the first violation with its cause, class and PC, and holds a tag exception request to the controller until it is acknowledged.
- Counts violations for software profiling.

---
 rtl/riscv_tag_check_unit.sv | 122 ++++++++++++
 tb/tb_riscv_tag_check_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_tag_check_unit.sv
// Registered multi-bit DIFT tag check for EX: policy table, exception capture, violation counter.
// Define TAG_CHECK_COUNT_EN to build the saturating violation counter; otherwise viol_count_o is 0.
module riscv_tag_check_unit #(
    parameter int TAG_WIDTH = 1,
    parameter int N_CLASSES = 4,
    parameter int CNT_WIDTH = 16,
    localparam int CW = $clog2(N_CLASSES),
    localparam int PW = 3 * TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [CW-1:0]        class_i,
    input  logic [31:0]          pc_i,
    input  logic [TAG_WIDTH-1:0] tag_a_i,
    input  logic [TAG_WIDTH-1:0] tag_b_i,
    input  logic [TAG_WIDTH-1:0] tag_d_i,
    input  logic                 cfg_we_i,
    input  logic [CW-1:0]        cfg_class_i,
    input  logic [PW-1:0]        cfg_wdata_i,
    output logic [PW-1:0]        cfg_rdata_o,
    output logic                 exc_req_o,
    input  logic                 exc_ack_i,
    output logic [2:0]           exc_cause_o,
    output logic [CW-1:0]        exc_class_o,
    output logic [31:0]          exc_pc_o,
    output logic                 exc_overflow_o,
    input  logic                 count_clr_i,
    output logic [CNT_WIDTH-1:0] viol_count_o
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] policy_q [N_CLASSES];
    logic [PW-1:0] pol;
    logic [2:0]    hit;
    logic          viol;
    logic          class_ok, cfg_ok;
    logic          capture, ovf_set;

    assign class_ok = int'(class_i) < N_CLASSES;
    assign cfg_ok   = int'(cfg_class_i) < N_CLASSES;

    // Out-of-range classes behave as an all-zero (no check) policy.
    always_comb begin
        pol = '0;
        if (class_ok) pol = policy_q[class_i];
    end

    always_comb begin
        cfg_rdata_o = '0;
        if (cfg_ok) cfg_rdata_o = policy_q[cfg_class_i];
    end

    assign hit[0] = |(tag_a_i & pol[TAG_WIDTH-1:0]);
    assign hit[1] = |(tag_b_i & pol[2*TAG_WIDTH-1:TAG_WIDTH]);
    assign hit[2] = |(tag_d_i & pol[PW-1:2*TAG_WIDTH]);
    assign viol   = valid_i & (|hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CLASSES; i++) policy_q[i] <= '0;
        end else if (cfg_we_i && cfg_ok) begin
            policy_q[cfg_class_i] <= cfg_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (viol) state_d = PEND;
            PEND: if (exc_ack_i && !viol) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An ack frees the capture registers, so a same-cycle violation replaces the old one.
    always_comb begin
        exc_req_o = (state_q == PEND);
        capture   = viol & ((state_q == IDLE) | exc_ack_i);
        ovf_set   = viol & (state_q == PEND) & ~exc_ack_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_cause_o <= '0;
            exc_class_o <= '0;
            exc_pc_o    <= '0;
        end else if (capture) begin
            exc_cause_o <= hit;
            exc_class_o <= class_i;
            exc_pc_o    <= pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)              exc_overflow_o <= 1'b0;
        else if (count_clr_i) exc_overflow_o <= ovf_set;
        else if (ovf_set)     exc_overflow_o <= 1'b1;
    end

`ifdef TAG_CHECK_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)                   cnt_q <= '0;
        else if (count_clr_i)      cnt_q <= CNT_WIDTH'(viol);
        else if (viol && ~&cnt_q)  cnt_q <= cnt_q + CNT_WIDTH'(1);
    end

    assign viol_count_o = cnt_q;
`else
    assign viol_count_o = '0;
`endif

endmodule

// File: tb/tb_riscv_tag_check_unit.sv
// Directed table-driven bench for riscv_tag_check_unit (TAG_WIDTH=2, N_CLASSES=4).
// A second instance with CNT_WIDTH=2 shares stimulus to observe counter saturation.
module tb_riscv_tag_check_unit;

`ifdef TAG_CHECK_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [1:0]  class_i;
    logic [31:0] pc_i;
    logic [1:0]  tag_a_i, tag_b_i, tag_d_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_class_i;
    logic [5:0]  cfg_wdata_i;
    logic [5:0]  cfg_rdata_o, cfg_rdata2;
    logic        exc_req_o, exc_req2;
    logic        exc_ack_i;
    logic [2:0]  exc_cause_o, exc_cause2;
    logic [1:0]  exc_class_o, exc_class2;
    logic [31:0] exc_pc_o, exc_pc2;
    logic        exc_overflow_o, exc_ovf2;
    logic        count_clr_i;
    logic [15:0] viol_count_o;
    logic [1:0]  viol_count2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_tag_check_unit #(.TAG_WIDTH(2), .N_CLASSES(4), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .class_i(class_i), .pc_i(pc_i),
        .tag_a_i(tag_a_i), .tag_b_i(tag_b_i), .tag_d_i(tag_d_i),
        .cfg_we_i(cfg_we_i), .cfg_class_i(cfg_class_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata_o), .exc_req_o(exc_req_o), .exc_ack_i(exc_ack_i),
        .exc_cause_o(exc_cause_o), .exc_class_o(exc_class_o), .exc_pc_o(exc_pc_o),
        .exc_overflow_o(exc_overflow_o), .count_clr_i(count_clr_i),
        .viol_count_o(viol_count_o)
    );

    riscv_tag_check_unit #(.TAG_WIDTH(2), .N_CLASSES(4), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .valid_i(valid_i), .class_i(class_i), .pc_i(pc_i),
        .tag_a_i(tag_a_i), .tag_b_i(tag_b_i), .tag_d_i(tag_d_i),
        .cfg_we_i(cfg_we_i), .cfg_class_i(cfg_class_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata2), .exc_req_o(exc_req2), .exc_ack_i(exc_ack_i),
        .exc_cause_o(exc_cause2), .exc_class_o(exc_class2), .exc_pc_o(exc_pc2),
        .exc_overflow_o(exc_ovf2), .count_clr_i(count_clr_i),
        .viol_count_o(viol_count2)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  cls;
        logic [31:0] pc;
        logic [1:0]  ta, tb, td;
        logic        ack, clr, we;
        logic [1:0]  wcls;
        logic [5:0]  wdata;
        logic        req;
        logic [2:0]  cause;
        logic [1:0]  ecls;
        logic [31:0] epc;
        logic        ovf;
        int          cnt;
        int          cnt2;
        logic [5:0]  rd;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_i     = v.valid;
        class_i     = v.cls;
        pc_i        = v.pc;
        tag_a_i     = v.ta;
        tag_b_i     = v.tb;
        tag_d_i     = v.td;
        exc_ack_i   = v.ack;
        count_clr_i = v.clr;
        cfg_we_i    = v.we;
        cfg_class_i = v.wcls;
        cfg_wdata_i = v.wdata;
    endtask

    task automatic idle_inputs();
        valid_i = 0; class_i = 0; pc_i = 0;
        tag_a_i = 0; tag_b_i = 0; tag_d_i = 0;
        exc_ack_i = 0; count_clr_i = 0;
        cfg_we_i = 0; cfg_class_i = 0; cfg_wdata_i = 0;
    endtask

    initial begin
        // valid cls pc ta tb td ack clr we wcls wdata | req cause ecls epc ovf cnt cnt2 rd
        vt[0]  = '{1,0,32'h000,2'b11,0,0,0,0,0,0,6'h00, 0,3'b000,0,32'h000,0,0,0,6'h00};
        vt[1]  = '{0,0,32'h000,0,0,0,0,0,1,0,6'b000010, 0,3'b000,0,32'h000,0,0,0,6'b000010};
        vt[2]  = '{1,0,32'h100,2'b10,0,0,0,0,0,0,6'h00, 1,3'b001,0,32'h100,0,1,1,6'b000010};
        vt[3]  = '{1,0,32'h104,2'b01,0,0,1,0,0,0,6'h00, 0,3'b001,0,32'h100,0,1,1,6'b000010};
        vt[4]  = '{1,0,32'h108,2'b10,0,0,0,0,0,0,6'h00, 1,3'b001,0,32'h108,0,2,2,6'b000010};
        vt[5]  = '{0,0,32'h000,0,0,0,0,0,1,2,6'b010000, 1,3'b001,0,32'h108,0,2,2,6'b010000};
        vt[6]  = '{1,2,32'h204,0,0,2'b01,1,0,0,0,6'h00, 1,3'b100,2,32'h204,0,3,3,6'b000010};
        vt[7]  = '{1,0,32'h300,2'b10,0,0,0,0,0,0,6'h00, 1,3'b100,2,32'h204,1,4,3,6'b000010};
        vt[8]  = '{1,0,32'h304,2'b10,0,0,0,0,0,0,6'h00, 1,3'b100,2,32'h204,1,5,3,6'b000010};
        vt[9]  = '{0,0,32'h000,0,0,0,0,1,0,0,6'h00, 1,3'b100,2,32'h204,0,0,0,6'b000010};
        vt[10] = '{0,0,32'h000,0,0,0,1,0,0,0,6'h00, 0,3'b100,2,32'h204,0,0,0,6'b000010};
        vt[11] = '{1,0,32'h400,2'b01,0,0,0,0,1,0,6'b000011, 0,3'b000,0,32'h000,0,0,0,6'b000011};
        vt[12] = '{1,0,32'h404,2'b01,0,0,0,0,0,0,6'h00, 1,3'b001,0,32'h404,0,1,1,6'b000011};
        vt[13] = '{1,0,32'h408,2'b01,0,0,0,1,0,0,6'h00, 1,3'b001,0,32'h404,1,1,1,6'b000011};
        vt[14] = '{0,0,32'h000,0,0,0,1,0,0,0,6'h00, 0,3'b000,0,32'h000,1,1,1,6'b000011};
        vt[15] = '{0,0,32'h000,0,0,0,0,1,0,0,6'h00, 0,3'b000,0,32'h000,0,0,0,6'b000011};
        for (int i = 0; i < 5; i++) begin
            vt[16+i] = '{1,0,32'h500 + 32'(4*i),2'b11,0,0,1,0,0,0,6'h00,
                         1,3'b001,0,32'h500 + 32'(4*i),0,i+1,(i+1 > 3) ? 3 : i+1,6'b000011};
        end

        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(exc_req_o), 0);
        chk("rst_cause", 32'(exc_cause_o), 0);
        chk("rst_class", 32'(exc_class_o), 0);
        chk("rst_pc", exc_pc_o, 0);
        chk("rst_ovf", 32'(exc_overflow_o), 0);
        chk("rst_cnt", 32'(viol_count_o), 0);
        chk("rst_rd", 32'(cfg_rdata_o), 0);
        rst = 0;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req", i), 32'(exc_req_o), 32'(vt[i].req));
            if (vt[i].req) begin
                chk($sformatf("v%0d_cause", i), 32'(exc_cause_o), 32'(vt[i].cause));
                chk($sformatf("v%0d_class", i), 32'(exc_class_o), 32'(vt[i].ecls));
                chk($sformatf("v%0d_pc", i), exc_pc_o, vt[i].epc);
            end
            chk($sformatf("v%0d_ovf", i), 32'(exc_overflow_o), 32'(vt[i].ovf));
            chk($sformatf("v%0d_cnt", i), 32'(viol_count_o), CNT_EN ? vt[i].cnt : 0);
            chk($sformatf("v%0d_cnt_sat", i), 32'(viol_count2), CNT_EN ? vt[i].cnt2 : 0);
            chk($sformatf("v%0d_rd", i), 32'(cfg_rdata_o), 32'(vt[i].rd));
        end

        // Reset while an exception is pending discards it and clears the table.
        idle_inputs();
        valid_i = 1; tag_a_i = 2'b11; pc_i = 32'h600;
        @(posedge clk);
        #1;
        chk("pre_rst_req", 32'(exc_req_o), 1);
        rst = 1;
        @(posedge clk);
        #1;
        chk("midrst_req", 32'(exc_req_o), 0);
        chk("midrst_rd", 32'(cfg_rdata_o), 0);
        chk("midrst_cnt", 32'(viol_count_o), 0);
        chk("midrst_pc", exc_pc_o, 0);
        rst = 0;
        @(posedge clk);
        #1;
        chk("postrst_req", 32'(exc_req_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
